// File: rtl/fixed_integer_bias_relu_collector.sv
// Bias-add, saturate and optional ReLU on each neuron result; buffers one
// layer and streams it out in MULTS-wide valid/ready chunks.
module fixed_integer_bias_relu_collector #(
  parameter int BITS    = 16,
  parameter int NEURONS = 10,
  parameter int MULTS   = 2,
  parameter int RELU    = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       load_bias,
  input  logic [BITS-1:0]            bias_in,
  input  logic                       in_valid,
  input  logic [BITS-1:0]            in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MULTS-1:0][BITS-1:0] out_data,
  output logic                       out_last,
  output logic                       overflow
);

  localparam int CHUNKS = (NEURONS + MULTS - 1) / MULTS;
  localparam int WI = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int RI = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_t;

  state_t          state, state_nx;
  logic [WI-1:0]   wr_idx, wr_nx;
  logic [RI-1:0]   rd_idx, rd_nx;
  logic [BITS-1:0] mem  [NEURONS];
  logic [BITS-1:0] bias [NEURONS];
  logic            ovf_q;

  logic            collecting;
  logic            take;
  logic            bias_en;
  logic            wr_last;
  logic            rd_last;
  logic [BITS-1:0] cur_bias;
  logic [BITS:0]   sum;
  logic [BITS-1:0] sat;
  logic [BITS-1:0] res;

  assign collecting = (state == COLLECT);
  assign take       = collecting && in_valid;
  assign bias_en    = load_bias && collecting
                   && (wr_idx == '0);
  assign wr_last    = (wr_idx == WI'(NEURONS - 1));
  assign rd_last    = (rd_idx == RI'(CHUNKS - 1));
  assign cur_bias   = bias[wr_idx];

  assign sum = {in_data[BITS-1], in_data}
             + {cur_bias[BITS-1], cur_bias};

  // sign bits disagree only when the BITS-wide result wrapped
  always_comb begin
    sat = sum[BITS-1:0];
    if (sum[BITS] != sum[BITS-1]) begin
      sat = sum[BITS] ? {1'b1, {(BITS-1){1'b0}}}
                      : {1'b0, {(BITS-1){1'b1}}};
    end
    res = sat;
    if (RELU != 0 && sat[BITS-1]) begin
      res = '0;
    end
  end

  always_comb begin
    state_nx = state;
    wr_nx    = wr_idx;
    rd_nx    = rd_idx;
    unique case (state)
      COLLECT: begin
        if (in_valid) begin
          if (wr_last) begin
            state_nx = DRAIN;
            wr_nx    = '0;
            rd_nx    = '0;
          end else begin
            wr_nx = wr_idx + WI'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_last) begin
            state_nx = COLLECT;
            rd_nx    = '0;
          end else begin
            rd_nx = rd_idx + RI'(1);
          end
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= COLLECT;
      wr_idx <= '0;
      rd_idx <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        mem[i]  <= '0;
        bias[i] <= '0;
      end
    end else begin
      state  <= state_nx;
      wr_idx <= wr_nx;
      rd_idx <= rd_nx;
      if (take) begin
        mem[wr_idx] <= res;
      end
      if (bias_en) begin
        bias[0] <= bias_in;
        for (int i = 1; i < NEURONS; i++) begin
          bias[i] <= bias[i-1];
        end
      end
      if (in_valid && !collecting) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // chunk view of the buffer; slots past the layer end read as zero
  logic [MULTS-1:0][BITS-1:0] chunk [CHUNKS];

  for (genvar c = 0; c < CHUNKS; c++) begin : g_chunk
    for (genvar j = 0; j < MULTS; j++) begin : g_word
      if (c * MULTS + j < NEURONS) begin : g_buf
        assign chunk[c][j] = mem[c*MULTS+j];
      end else begin : g_pad
        assign chunk[c][j] = '0;
      end
    end
  end

  assign out_data  = chunk[rd_idx];
  assign out_valid = (state == DRAIN);
  assign out_last  = out_valid && rd_last;
  assign in_ready  = collecting;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fixed_integer_bias_relu_collector.sv
// Directed bench: 5-neuron ReLU layer with padding, plus a
// single-neuron signed (no ReLU) instance for saturation corners.
module tb_fixed_integer_bias_relu_collector;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic             load_bias, in_valid, out_ready;
  logic [15:0]      bias_in, in_data;
  logic             in_ready, out_valid, out_last, overflow;
  logic [1:0][15:0] out_data;

  logic             r_load_bias, r_in_valid, r_out_ready;
  logic [15:0]      r_bias_in, r_in_data;
  logic             r_in_ready, r_out_valid, r_out_last, r_overflow;
  logic [1:0][15:0] r_out_data;

  int total = 0;
  int bad   = 0;

  fixed_integer_bias_relu_collector #(
    .BITS(16), .NEURONS(5), .MULTS(2), .RELU(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .load_bias(load_bias), .bias_in(bias_in),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .overflow(overflow)
  );

  fixed_integer_bias_relu_collector #(
    .BITS(16), .NEURONS(1), .MULTS(2), .RELU(0)
  ) dut_s (
    .clk(clk), .rstn(rstn),
    .load_bias(r_load_bias), .bias_in(r_bias_in),
    .in_valid(r_in_valid), .in_data(r_in_data),
    .in_ready(r_in_ready),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .out_data(r_out_data), .out_last(r_out_last),
    .overflow(r_overflow)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_layer(input bit do_bias,
                            input logic [0:4][15:0] b,
                            input logic [0:4][15:0] d);
    if (do_bias) begin
      for (int i = 0; i < 5; i++) begin
        load_bias = 1'b1;
        bias_in   = b[i];
        tick();
      end
      load_bias = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      check("coll_valid", 32'(out_valid), 0);
      in_valid = 1'b1;
      in_data  = d[i];
      tick();
    end
    in_valid = 1'b0;
    check("lat_valid", 32'(out_valid), 1);
  endtask

  task automatic drain(input logic [0:5][15:0] e,
                       input int stall_chunk,
                       input int nstall);
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0;
      for (int s = 0; s < nstall; s++) begin
        if (c == stall_chunk) begin
          check("hold_valid", 32'(out_valid), 1);
          check("hold_w0", 32'(out_data[0]), 32'(e[2*c]));
          check("hold_w1", 32'(out_data[1]), 32'(e[2*c+1]));
          check("hold_last", 32'(out_last), 32'(c == 2));
          tick();
        end
      end
      out_ready = 1'b1;
      check("chunk_valid", 32'(out_valid), 1);
      check("chunk_w0", 32'(out_data[0]), 32'(e[2*c]));
      check("chunk_w1", 32'(out_data[1]), 32'(e[2*c+1]));
      check("chunk_last", 32'(out_last), 32'(c == 2));
      tick();
    end
    out_ready = 1'b0;
    check("back_valid", 32'(out_valid), 0);
    check("back_ready", 32'(in_ready), 1);
  endtask

  task automatic r_take(input logic [15:0] exp);
    check("s_valid", 32'(r_out_valid), 1);
    check("s_w0", 32'(r_out_data[0]), 32'(exp));
    check("s_pad", 32'(r_out_data[1]), 0);
    check("s_last", 32'(r_out_last), 1);
    r_out_ready = 1'b1;
    tick();
    r_out_ready = 1'b0;
    check("s_ready", 32'(r_in_ready), 1);
  endtask

  logic [0:4][15:0] bias_v;
  logic [0:4][15:0] data_a;
  logic [0:4][15:0] data_b;
  logic [0:5][15:0] exp_a;
  logic [0:5][15:0] exp_b;
  logic [0:5][15:0] exp_z;

  initial begin
    // load order is k=4..0: biases 10,-20,0,5,1
    bias_v = {16'd1, 16'd5, 16'd0, 16'hFFEC, 16'd10};
    data_a = {16'd5, 16'd10, 16'hFFFD, 16'h7FFF, 16'hFFFF};
    data_b = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    exp_a  = {16'd15, 16'd0, 16'd0, 16'h7FFF, 16'd0, 16'd0};
    exp_b  = {16'd11, 16'd0, 16'd3, 16'd9, 16'd6, 16'd0};
    exp_z  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0};

    rstn = 1'b0;
    load_bias = 1'b0; bias_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    r_load_bias = 1'b0; r_bias_in = '0;
    r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    check("rst_valid", 32'(out_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_last", 32'(out_last), 0);

    // signed instance: saturation corners and bias/input same cycle
    r_load_bias = 1'b1; r_bias_in = 16'hFFFF;
    tick();
    r_load_bias = 1'b0;
    r_in_valid = 1'b1; r_in_data = 16'h8000;
    tick();
    r_in_valid = 1'b0;
    r_take(16'h8000);
    r_load_bias = 1'b1; r_bias_in = 16'h0000;
    tick();
    r_load_bias = 1'b0;
    r_in_valid = 1'b1; r_in_data = 16'hFFF0;
    tick();
    r_in_valid = 1'b0;
    r_take(16'hFFF0);
    r_load_bias = 1'b1; r_bias_in = 16'd5;
    r_in_valid = 1'b1; r_in_data = 16'h0010;
    tick();
    r_load_bias = 1'b0; r_in_valid = 1'b0;
    r_take(16'h0010);
    r_in_valid = 1'b1; r_in_data = 16'h0000;
    tick();
    r_in_valid = 1'b0;
    r_take(16'd5);

    load_layer(1'b1, bias_v, data_a);
    drain(exp_a, -1, 0);

    load_layer(1'b1, bias_v, data_a);
    drain(exp_a, 1, 3);

    load_layer(1'b1, bias_v, data_a);
    in_valid = 1'b1; in_data = 16'd7;
    tick();
    in_valid = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    drain(exp_a, -1, 0);
    check("ovf_sticky", 32'(overflow), 1);
    load_layer(1'b0, bias_v, data_b);
    drain(exp_b, -1, 0);
    check("ovf_sticky2", 32'(overflow), 1);

    load_layer(1'b0, bias_v, data_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_valid", 32'(out_valid), 0);
    check("mid_ready", 32'(in_ready), 1);
    check("mid_ovf", 32'(overflow), 0);
    load_layer(1'b0, bias_v, data_b);
    drain(exp_z, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
